// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential multiplier.
//   state_t                 : controller states IDLE / BUSY / DONE
//   DEFAULT_DATA_WIDTH      : default operand width in bits
//   DEFAULT_BITS_PER_CYCLE  : default multiplier bits retired per BUSY cycle
package multiplier_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_BITS_PER_CYCLE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_step.sv
// One shift-add step of the unsigned magnitude multiplication.
//   acc      : current accumulator (2*DATA_WIDTH bits)
//   mcand    : multiplicand magnitude
//   slice    : next BITS_PER_CYCLE multiplier-magnitude bits
//   pos      : bit position of slice within the multiplier
//   acc_next : acc + (mcand * slice) << pos
module multiplier_step
  import multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic [2*DATA_WIDTH-1:0]       acc,
  input  logic [DATA_WIDTH-1:0]         mcand,
  input  logic [BITS_PER_CYCLE-1:0]     slice,
  input  logic [$clog2(DATA_WIDTH)-1:0] pos,
  output logic [2*DATA_WIDTH-1:0]       acc_next
);

  logic [2*DATA_WIDTH-1:0] mcand_ext;
  logic [2*DATA_WIDTH-1:0] slice_ext;
  logic [2*DATA_WIDTH-1:0] partial;

  // Partial product fits in DATA_WIDTH+BITS_PER_CYCLE bits, so the
  // 2*DATA_WIDTH-bit accumulator never overflows.
  always_comb begin
    mcand_ext = {{DATA_WIDTH{1'b0}}, mcand};
    slice_ext = {{(2*DATA_WIDTH-BITS_PER_CYCLE){1'b0}}, slice};
    partial   = mcand_ext * slice_ext;
    acc_next  = acc + (partial << pos);
  end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier, signed or unsigned, with valid/ready
// handshakes on both sides.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : input1/input2/signed_mode are valid
//   in_ready     : high only in IDLE
//   input1       : multiplicand
//   input2       : multiplier
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   out_valid    : high only in DONE, outputValue holds the product
//   out_ready    : consumer accepts the product
//   outputValue  : exact 2*DATA_WIDTH-bit product
module multiplier_seq
  import multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   input1,
  input  logic [DATA_WIDTH-1:0]   input2,
  input  logic                    signed_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] outputValue
);

  localparam int unsigned STEPS = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned POS_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_INC  = POS_W'(BITS_PER_CYCLE);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [POS_W-1:0]        pos;
  logic                    negate;

  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;

  // Magnitudes of the incoming operands. The most-negative value maps to
  // 2^(DATA_WIDTH-1), which is still exact as an unsigned DATA_WIDTH value.
  always_comb begin
    a_neg = signed_mode & input1[DATA_WIDTH-1];
    b_neg = signed_mode & input2[DATA_WIDTH-1];
    a_mag = a_neg ? ('0 - input1) : input1;
    b_mag = b_neg ? ('0 - input2) : input2;
  end

  multiplier_step #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .slice    (mplier[BITS_PER_CYCLE-1:0]),
    .pos      (pos),
    .acc_next (acc_next)
  );

  // signed_mode is only needed to decide the final sign, so only the
  // resulting negate flag is latched at acceptance. Negating a zero
  // accumulator yields zero, so a zero product stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      pos         <= '0;
      negate      <= 1'b0;
      outputValue <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            negate   <= a_neg ^ b_neg;
            acc      <= '0;
            cnt      <= CNT_LOAD;
            pos      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> BITS_PER_CYCLE;
          pos    <= pos + POS_INC;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            outputValue <= negate ? ('0 - acc_next) : acc_next;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits (legal values 2 to 32).
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, multiplier bits retired per BUSY cycle; DATA_WIDTH % BITS_PER_CYCLE SHALL be 0.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port input1  input  DATA_WIDTH  multiplicand.
REQ-008 SHALL have port input2  input  DATA_WIDTH  multiplier.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-010 SHALL have port out_valid  output  1  outputValue holds the result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port outputValue  output  2*DATA_WIDTH  product.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-015 SHALL accept operands on an edge with in_valid && in_ready: latch input1, input2 and signed_mode, clear the accumulator, load STEPS = DATA_WIDTH/BITS_PER_CYCLE into the counter, and go to BUSY.
REQ-016 SHALL, in each BUSY cycle, add (multiplicand magnitude × next BITS_PER_CYCLE multiplier-magnitude bits, LSB first) shifted to the current position, then decrement the counter.
REQ-017 SHALL, on the edge that retires the last step, move BUSY to DONE, so that out_valid rises exactly STEPS rising edges after the accepting edge (8 for the defaults).
REQ-018 SHALL, in signed mode, take operand magnitudes and negate the 2*DATA_WIDTH-bit result iff the operand signs differ; a zero result SHALL never be negated to a nonzero value.
REQ-019 SHALL handle the most-negative operand, magnitude 2^(DATA_WIDTH-1), exactly, as an unsigned DATA_WIDTH-bit value.
REQ-020 SHALL make every product exact in 2*DATA_WIDTH bits, with no truncation or overflow in either mode.
REQ-021 SHALL hold outputValue stable while out_valid && !out_ready, for any stall length.
REQ-022 SHALL, on an edge with out_valid && out_ready, go DONE to IDLE; in_ready SHALL be 1 in the following cycle, so no new operand is taken in that same edge.
REQ-023 SHALL ignore in_valid and operand changes while in BUSY or DONE.
REQ-024 SHALL ignore out_ready while in IDLE or BUSY.

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-BUSY or in DONE), immediately force: state IDLE, counter 0, accumulator 0, outputValue 0, out_valid 0, in_ready 1.
REQ-026 SHALL discard any in-flight operation on reset; the first operation after rst_n rises SHALL be independent of pre-reset history.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/BUSY/DONE) and the default parameter constants in shared package multiplier_pkg.
REQ-028 SHALL place the per-cycle shift-add in one combinational sub-module, multiplier_step, parameterised by DATA_WIDTH and BITS_PER_CYCLE (inputs: accumulator, multiplicand, multiplier bit slice, shift position; output: next accumulator).
REQ-029 SHALL keep the sign correction (REQ-018) in multiplier_seq, not in multiplier_step.

Verification
REQ-030 SHALL cover unsigned 8-bit defaults: input1 = 0xFF, input2 = 0xFF, signed_mode = 0 -> outputValue = 0xFE01, out_valid 8 edges after acceptance.
REQ-031 SHALL cover signed mode: input1 = 0x80 (-128), input2 = 0x80 -> 0x4000; input1 = 0x80, input2 = 0x01 -> 0xFF80; input1 = 0x00, input2 = 0x85 -> 0x0000.
REQ-032 SHALL cover BITS_PER_CYCLE = 4, DATA_WIDTH = 8: input1 = 0xA5, input2 = 0x3C, unsigned -> 0x26AC, out_valid after 2 edges.
REQ-033 SHALL cover backpressure: hold out_ready = 0 for 20 cycles in DONE -> outputValue stable, in_ready 0, and new in_valid ignored; then out_ready = 1 -> IDLE next cycle.
REQ-034 SHALL cover reset mid-BUSY: assert rst_n = 0 at step 3 of 8 -> all outputs at reset values immediately; after release, 3 × 7 unsigned -> 0x0015.
REQ-035 SHALL cover a random back-to-back regression (1000 operations, both modes, DATA_WIDTH in {4, 8, 16}, BITS_PER_CYCLE in {1, 2}) -> every result equal to the reference product.
